// File: rtl/triagem_peso_uc.sv
// -----------------------------------------------------------------------------
// triagem_peso_uc
// Control unit for the weight-sorting datapath. Digit bytes from the UART are
// framed into the digit shift register; a '#' byte triggers evaluation of the
// range comparators. An accepted weight sweeps the servo from position 0 to 7,
// one step per timer interval, holds at 7, then returns it to 0. Rejected and
// erroneous frames only raise their flag. Moore machine: every control output
// is decoded from the current state.
//
// Parameters
//   N_BYTES         digit bytes expected per frame (exists only with FRAME_CHECK_EN)
//   HOLD_INTERVALS  timer terminal counts spent holding at position 7 (1..16)
//
// Configuration macro
//   FRAME_CHECK_EN  when defined, a frame whose digit count differs from
//                   N_BYTES is flagged as an error before any range test.
//                   When undefined, the byte count is not checked.
//
// Ports
//   clock                 in   system clock
//   reset                 in   asynchronous active-high reset
//   fimRecepcao           in   1-cycle pulse, received byte valid
//   comando               in   current byte is '#'
//   perteceAoIntervalo    in   pesoMin <= pesoAtual <= pesoMax
//   pesoMaxIgualZero      in   pesoMax == 0
//   fimContadorIntervalo  in   interval timer terminal count
//   inicioPosicao         in   servo position == 0
//   fimPosicao            in   servo position == 7
//   zeraUpdown            out  synchronous clear of the position counter
//   contaUpdown           out  advance the position counter by one
//   zeraIntervalo         out  synchronous clear of the interval timer
//   contaIntervalo        out  interval timer enable
//   enableReg             out  shift the current digit into the register
//   aceito/rejeitado/erro out  frame result flags, held until the next frame
//   ocupado               out  busy evaluating / moving the servo
//   db_estado             out  current state code
// -----------------------------------------------------------------------------
module triagem_peso_uc #(
`ifdef FRAME_CHECK_EN
  parameter int N_BYTES        = 6,
`endif
  parameter int HOLD_INTERVALS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fimRecepcao,
  input  logic       comando,
  input  logic       perteceAoIntervalo,
  input  logic       pesoMaxIgualZero,
  input  logic       fimContadorIntervalo,
  input  logic       inicioPosicao,
  input  logic       fimPosicao,
  output logic       zeraUpdown,
  output logic       contaUpdown,
  output logic       zeraIntervalo,
  output logic       contaIntervalo,
  output logic       enableReg,
  output logic       aceito,
  output logic       rejeitado,
  output logic       erro,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  // State codes follow the order in which the states are described.
  localparam logic [3:0] S_INICIAL  = 4'd0;
  localparam logic [3:0] S_ESPERA   = 4'd1;
  localparam logic [3:0] S_REGISTRA = 4'd2;
  localparam logic [3:0] S_AVALIA   = 4'd3;
  localparam logic [3:0] S_SOBE     = 4'd4;
  localparam logic [3:0] S_AGUARDA  = 4'd5;
  localparam logic [3:0] S_PASSO    = 4'd6;
  localparam logic [3:0] S_SEGURA   = 4'd7;
  localparam logic [3:0] S_RETORNA  = 4'd8;
  localparam logic [3:0] S_REJEITA  = 4'd9;
  localparam logic [3:0] S_ERRO     = 4'd10;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_INTERVALS - 1);
`ifdef FRAME_CHECK_EN
  localparam logic [3:0] FRAME_LEN = 4'(N_BYTES);
`endif

  logic [3:0] state_q, state_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       aceito_q, aceito_d;
  logic       rejeitado_q, rejeitado_d;
  logic       erro_q, erro_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_INICIAL;
      byte_cnt_q  <= 4'd0;
      hold_cnt_q  <= 4'd0;
      aceito_q    <= 1'b0;
      rejeitado_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      aceito_q    <= aceito_d;
      rejeitado_q <= rejeitado_d;
      erro_q      <= erro_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    aceito_d    = aceito_q;
    rejeitado_d = rejeitado_q;
    erro_d      = erro_q;
    case (state_q)
      S_INICIAL: begin
        byte_cnt_d = 4'd0;
        state_d    = S_ESPERA;
      end
      S_ESPERA: begin
        if (fimRecepcao) begin
          // byte_cnt is zero only before the first byte of a frame, so the
          // previous result is dropped exactly when a new frame starts.
          if (byte_cnt_q == 4'd0) begin
            aceito_d    = 1'b0;
            rejeitado_d = 1'b0;
            erro_d      = 1'b0;
          end
          state_d = comando ? S_AVALIA : S_REGISTRA;
        end
      end
      S_REGISTRA: begin
        if (byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
        state_d = S_ESPERA;
      end
      S_AVALIA: begin
`ifdef FRAME_CHECK_EN
        if (byte_cnt_q != FRAME_LEN)  state_d = S_ERRO;
        else if (pesoMaxIgualZero)    state_d = S_ERRO;
        else if (perteceAoIntervalo)  state_d = S_SOBE;
        else                          state_d = S_REJEITA;
`else
        if (pesoMaxIgualZero)         state_d = S_ERRO;
        else if (perteceAoIntervalo)  state_d = S_SOBE;
        else                          state_d = S_REJEITA;
`endif
      end
      S_SOBE: state_d = S_AGUARDA;
      S_AGUARDA: begin
        if (fimContadorIntervalo) begin
          if (fimPosicao) begin
            hold_cnt_d = 4'd0;
            state_d    = S_SEGURA;
          end else begin
            state_d = S_PASSO;
          end
        end
      end
      S_PASSO: state_d = S_AGUARDA;
      S_SEGURA: begin
        if (fimContadorIntervalo) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
          if (hold_cnt_q == HOLD_LAST) state_d = S_RETORNA;
        end
      end
      S_RETORNA: begin
        if (inicioPosicao) begin
          aceito_d = 1'b1;
          state_d  = S_INICIAL;
        end
      end
      S_REJEITA: begin
        rejeitado_d = 1'b1;
        state_d     = S_INICIAL;
      end
      S_ERRO: begin
        erro_d  = 1'b1;
        state_d = S_INICIAL;
      end
      default: state_d = S_INICIAL;
    endcase
  end

  // Moore output decode.
  always_comb begin
    zeraUpdown     = (state_q == S_INICIAL) || (state_q == S_RETORNA);
    zeraIntervalo  = (state_q == S_INICIAL) || (state_q == S_SOBE) || (state_q == S_PASSO);
    contaIntervalo = (state_q == S_AGUARDA) || (state_q == S_SEGURA);
    contaUpdown    = (state_q == S_PASSO);
    enableReg      = (state_q == S_REGISTRA);
    // Every state from AVALIA onward belongs to evaluation or servo motion.
    ocupado        = (state_q >= S_AVALIA) && (state_q <= S_ERRO);
  end

  assign aceito    = aceito_q;
  assign rejeitado = rejeitado_q;
  assign erro      = erro_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_triagem_peso_uc.sv
`timescale 1ns/1ps
module tb_triagem_peso_uc;

  localparam int NB    = 6;   // digits per complete frame
  localparam int HOLD  = 2;   // hold intervals at position 7
  localparam int T_INT = 4;   // interval timer period in cycles
  localparam int STEPS = 7;   // servo travel 0 -> 7
`ifdef FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic fimRecepcao, comando, perteceAoIntervalo, pesoMaxIgualZero;
  logic fimContadorIntervalo, inicioPosicao, fimPosicao;
  logic zeraUpdown, contaUpdown, zeraIntervalo, contaIntervalo, enableReg;
  logic aceito, rejeitado, erro, ocupado;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  triagem_peso_uc dut (
    .clock(clock), .reset(reset),
    .fimRecepcao(fimRecepcao), .comando(comando),
    .perteceAoIntervalo(perteceAoIntervalo), .pesoMaxIgualZero(pesoMaxIgualZero),
    .fimContadorIntervalo(fimContadorIntervalo),
    .inicioPosicao(inicioPosicao), .fimPosicao(fimPosicao),
    .zeraUpdown(zeraUpdown), .contaUpdown(contaUpdown),
    .zeraIntervalo(zeraIntervalo), .contaIntervalo(contaIntervalo),
    .enableReg(enableReg), .aceito(aceito), .rejeitado(rejeitado), .erro(erro),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  // ---------------- datapath environment model ----------------
  int dig_reg [6] = '{default: 0};   // [0] oldest digit = pesoMax tens
  int cur_digit   = 0;
  int tmr         = 0;
  int pos         = 0;
  int p_max, p_min, p_atual;

  always @(posedge clock) begin
    if (enableReg) begin
      for (int i = 0; i < 5; i++) dig_reg[i] <= dig_reg[i+1];
      dig_reg[5] <= cur_digit;
    end
    if (zeraIntervalo)       tmr <= 0;
    else if (contaIntervalo) tmr <= (tmr + 1) % T_INT;
    if (zeraUpdown)          pos <= 0;
    else if (contaUpdown)    pos <= (pos + 1) % 8;
  end

  always_comb begin
    p_max   = dig_reg[0] * 10 + dig_reg[1];
    p_min   = dig_reg[2] * 10 + dig_reg[3];
    p_atual = dig_reg[4] * 10 + dig_reg[5];
    perteceAoIntervalo   = (p_min <= p_atual) && (p_atual <= p_max);
    pesoMaxIgualZero     = (p_max == 0);
    fimContadorIntervalo = (tmr == T_INT - 1);
    inicioPosicao        = (pos == 0);
    fimPosicao           = (pos == 7);
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int res; int n_reg; } exp_t;   // res: 0 accept, 1 reject, 2 error
  exp_t sb[$];
  int   ref_digits[$];   // every digit actually registered, oldest first
  int   frame_n = 0;     // digits registered in the frame being built
  int   checks  = 0;
  int   errors  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_expect();
    exp_t e;
    int n, mx, mn, at;
    n  = ref_digits.size();
    mx = ref_digits[n-6] * 10 + ref_digits[n-5];
    mn = ref_digits[n-4] * 10 + ref_digits[n-3];
    at = ref_digits[n-2] * 10 + ref_digits[n-1];
    e.n_reg = frame_n;
    if (FRAME_CHECK && frame_n != NB) e.res = 2;
    else if (mx == 0)                 e.res = 2;
    else if (mn <= at && at <= mx)    e.res = 0;
    else                              e.res = 1;
    sb.push_back(e);
    frame_n = 0;
  endtask

  task automatic send_byte(input int d, input bit hash, input bit dropped);
    @(negedge clock);
    cur_digit   = d;
    comando     = hash;
    fimRecepcao = 1'b1;
    @(negedge clock);
    fimRecepcao = 1'b0;
    if (!dropped) begin
      if (hash) push_expect();
      else begin
        ref_digits.push_back(d);
        frame_n++;
      end
    end
  endtask

  // Sends a frame such as "050203#"; the first byte must clear old flags.
  task automatic send_frame(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte ch;
      ch = s[i];
      if (ch == "#") send_byte(0, 1'b1, 1'b0);
      else           send_byte(int'(ch) - 48, 1'b0, 1'b0);
      if (i == 0) check("first_byte_clears_flags", int'({aceito, rejeitado, erro}), 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  task automatic wait_result();
    int c = 0;
    while (sb.size() != 0 && c < 3000) begin
      @(negedge clock);
      c++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout actual=pending required=result");
      sb.delete();
    end
  endtask

  task automatic wait_sweep_pos(input int p);
    int c = 0;
    while (!(pos == p && contaIntervalo) && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("reach_position", pos, p);
  endtask

  // ---------------- monitor ----------------
  int   m_reg = 0, m_steps = 0, m_hold = 0, m_maxpos = 0, m_viol = 0, m_frame = 0;
  logic p_fim_rx, p_cmd, p_fim_int, p_cint, any_flag, flags_prev = 1'b0;
  int   p_pos, exp_flags;
  exp_t m_e;

  always begin
    @(posedge clock);
    p_fim_rx  = fimRecepcao;
    p_cmd     = comando;
    p_fim_int = fimContadorIntervalo;
    p_cint    = contaIntervalo;
    p_pos     = pos;
    #1;
    if (reset) begin
      m_reg = 0; m_steps = 0; m_hold = 0; m_maxpos = 0; m_viol = 0;
      flags_prev = 1'b0;
    end else begin
      if (enableReg) begin
        m_reg++;
        if (!(p_fim_rx && !p_cmd)) m_viol++;   // must follow a digit byte by one cycle
        if (ocupado) m_viol++;
      end
      if (contaUpdown) begin
        m_steps++;
        if (!p_fim_int) m_viol++;              // one step per elapsed interval
      end
      if (p_cint && p_fim_int && p_pos == 7) m_hold++;
      if (contaIntervalo && !ocupado) m_viol++;
      if (pos > m_maxpos) m_maxpos = pos;
      any_flag = aceito | rejeitado | erro;
      if (any_flag && !flags_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%b required=none", {aceito, rejeitado, erro});
        end else begin
          m_e = sb.pop_front();
          exp_flags = (m_e.res == 0) ? 4 : (m_e.res == 1) ? 2 : 1;
          $display("frame %0d: flags(a,r,e)=%b expected=%03b regs=%0d steps=%0d hold=%0d",
                   m_frame, {aceito, rejeitado, erro}, exp_flags[2:0], m_reg, m_steps, m_hold);
          check("result_flags", int'({aceito, rejeitado, erro}), exp_flags);
          check("enableReg_pulses", m_reg, m_e.n_reg);
          check("contaUpdown_pulses", m_steps, (m_e.res == 0) ? STEPS : 0);
          check("max_position", m_maxpos, (m_e.res == 0) ? 7 : 0);
          // the interval that finds position 7 plus the hold intervals
          check("intervals_at_7", m_hold, (m_e.res == 0) ? 1 + HOLD : 0);
          check("timing_violations", m_viol, 0);
          check("final_position", pos, 0);
          check("result_state", int'(db_estado), 0);
        end
        m_frame++;
        m_reg = 0; m_steps = 0; m_hold = 0; m_maxpos = 0; m_viol = 0;
      end
      flags_prev = any_flag;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_db_estado"}, int'(db_estado), 0);
    check({tag, "_zeraUpdown"}, int'(zeraUpdown), 1);
    check({tag, "_zeraIntervalo"}, int'(zeraIntervalo), 1);
    check({tag, "_other_ctrl"}, int'({contaUpdown, contaIntervalo, enableReg, ocupado}), 0);
    check({tag, "_flags"}, int'({aceito, rejeitado, erro}), 0);
  endtask

  initial begin
    int mx, mn, at, n, kind;
    string s;
    reset = 1'b1;
    fimRecepcao = 1'b0;
    comando = 1'b0;
    for (int i = 0; i < 6; i++) ref_digits.push_back(0);
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);
    check("espera_after_reset", int'(db_estado), 1);

    // accepted weight; a byte arriving mid-sweep is dropped
    send_frame("050203#");
    wait_sweep_pos(4);
    check("ocupado_in_sweep", int'(ocupado), 1);
    send_byte(1, 1'b0, 1'b1);
    wait_result();
    check("aceito_held", int'(aceito), 1);
    repeat (3) @(negedge clock);
    check("aceito_still_held", int'(aceito), 1);

    // first byte of the next frame clears aceito; atual 9 exceeds max
    send_frame("050209#");
    wait_result();
    send_frame("000000#");
    wait_result();
    send_frame("0502#");
    wait_result();

    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 9);
      s = "";
      if (kind < 8) begin
        mx = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 99);
        mn = $urandom_range(0, 99);
        at = $urandom_range(0, 99);
        if ($urandom_range(0, 1) == 1 && mn <= mx) at = $urandom_range(mn, mx);
        s = $sformatf("%02d%02d%02d#", mx, mn, at);
      end else begin
        n = (kind == 8) ? $urandom_range(1, 5) : 7;
        for (int j = 0; j < n; j++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
        s = {s, "#"};
      end
      send_frame(s);
      wait_result();
    end

    // reset in the middle of a sweep, waiting at position 3
    send_frame("050203#");
    wait_sweep_pos(3);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midsweep_reset");
    sb.delete();
    repeat (2) @(negedge clock);
    check("position_after_reset", pos, 0);
    reset = 1'b0;
    @(negedge clock);
    check("espera_after_midsweep_reset", int'(db_estado), 1);

    send_frame("090109#");
    wait_result();
    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
